// File: rtl/watch_btn_ctrl.sv
// Button front end for the stopwatch/display core: sync, debounce and press-edge
// detection per button, then the mode FSM and the held command code.
module watch_btn_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int NBTN      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBTN-1:0] btn_n,
    output logic [3:0]      state,
    output logic [3:0]      flag,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_evt
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    localparam int B_MODE  = 0;
    localparam int B_START = 1;
    localparam int B_CLEAR = 2;
    localparam int B_SET   = 3;
    localparam int B_UP    = 4;
    localparam int B_DOWN  = 5;

    localparam logic [3:0] F_IDLE  = 4'd0;
    localparam logic [3:0] F_CLEAR = 4'd5;
    localparam logic [3:0] F_PAUSE = 4'd6;
    localparam logic [3:0] F_RUN   = 4'd7;
    localparam logic [3:0] F_EDIT  = 4'd8;
    localparam logic [3:0] F_INC   = 4'd9;
    localparam logic [3:0] F_DEC   = 4'd10;

    typedef enum logic [3:0] {
        ST_CLOCK = 4'd1,
        ST_SW    = 4'd2,
        ST_TIMER = 4'd3,
        ST_ALARM = 4'd4
    } mode_e;

    logic [NBTN-1:0] sync1_q, sync2_q, level_q, prev_q, evt_q;
    logic [CW-1:0]   cnt_q [NBTN];

    mode_e      state_q, state_d;
    logic [3:0] sw_q, sw_d, oth_q, oth_d, flag_q, flag_d;
    logic       inc_d, dec_d;

    // A level change is accepted only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            prev_q  <= '0;
            evt_q   <= '0;
            for (int i = 0; i < NBTN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= ~btn_n;
            sync2_q <= sync1_q;
            prev_q  <= level_q;
            evt_q   <= level_q & ~prev_q;
            for (int i = 0; i < NBTN; i++) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        level_q[i] <= sync2_q[i];
                        cnt_q[i]   <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    // Only the highest-priority event in a cycle acts; lower ones are dropped.
    always_comb begin
        state_d = state_q;
        sw_d    = sw_q;
        oth_d   = oth_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        case (state_q)
            ST_CLOCK, ST_SW, ST_TIMER, ST_ALARM: begin
                if (evt_q[B_MODE]) begin
                    oth_d = F_IDLE;
                    case (state_q)
                        ST_CLOCK: state_d = ST_SW;
                        ST_SW:    state_d = ST_TIMER;
                        ST_TIMER: state_d = ST_ALARM;
                        default:  state_d = ST_CLOCK;
                    endcase
                end else if (evt_q[B_CLEAR]) begin
                    if (state_q == ST_SW) sw_d = F_CLEAR;
                end else if (evt_q[B_START]) begin
                    if (state_q == ST_SW) sw_d = (sw_q == F_RUN) ? F_PAUSE : F_RUN;
                end else if (evt_q[B_SET]) begin
                    if (state_q != ST_SW) oth_d = (oth_q == F_EDIT) ? F_IDLE : F_EDIT;
                end else if (evt_q[B_UP]) begin
                    inc_d = (state_q != ST_SW) && (oth_q == F_EDIT);
                end else if (evt_q[B_DOWN]) begin
                    dec_d = (state_q != ST_SW) && (oth_q == F_EDIT);
                end
            end
            default: state_d = ST_CLOCK;
        endcase

        // INC/DEC are single-cycle overlays; oth_q itself stays at EDIT.
        if (state_d == ST_SW) flag_d = sw_d;
        else if (inc_d)       flag_d = F_INC;
        else if (dec_d)       flag_d = F_DEC;
        else                  flag_d = oth_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLOCK;
            sw_q    <= F_PAUSE;
            oth_q   <= F_IDLE;
            flag_q  <= F_IDLE;
        end else begin
            state_q <= state_d;
            sw_q    <= sw_d;
            oth_q   <= oth_d;
            flag_q  <= flag_d;
        end
    end

    assign state     = state_q;
    assign flag      = flag_q;
    assign btn_level = level_q;
    assign btn_evt   = evt_q;
endmodule
